// File: rtl/muskbus_pkg.sv
// Shared Muskbus constants, reader FSM states and the beat-to-line byte reorder.
package muskbus_pkg;

    localparam int LINE_BYTES     = 64;
    localparam int BEAT_BYTES     = 8;
    localparam int BEATS_PER_LINE = LINE_BYTES / BEAT_BYTES;

    localparam logic [15:0] TAG_MEM_READ = 16'h1800;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Bus beats are little-endian while the fetch line is big-endian by byte,
    // so the lowest-address beat byte must land in the most significant lane.
    function automatic logic [63:0] beat_to_line_order(input logic [63:0] beat);
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < BEAT_BYTES; j++) begin
            r[63-8*j -: 8] = beat[8*j +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/muskbus_reader.sv
// Instruction-fetch line reader: one aligned bus read, eight 64-bit beats,
// then a one-cycle completion pulse with the whole 64-byte line.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for rd_reqcyc; rd_data holds the last line
// ST_REQ  | bus request driven until bus_reqack
// ST_RESP | accepting beats into rd_data, beat counter advances per beat
// ST_DONE | rd_respcyc pulse, back to idle next cycle
module muskbus_reader
    import muskbus_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         rd_reqcyc,
    input  logic [63:0]  rd_addr,
    output logic         rd_respcyc,
    output logic [511:0] rd_data,
    output logic         bus_reqcyc,
    output logic [63:0]  bus_req,
    output logic [15:0]  bus_reqtag,
    input  logic         bus_reqack,
    input  logic         bus_respcyc,
    input  logic [63:0]  bus_resp,
    input  logic [15:0]  bus_resptag,
    output logic         bus_respack
);

    state_t      state;
    logic [2:0]  beat_cnt;
    logic [63:0] line_addr;

    // Responses are routed by the mux, so the tag is not needed here.
    logic unused_inputs;
    assign unused_inputs = ^{bus_resptag, rd_addr[5:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            beat_cnt  <= '0;
            line_addr <= '0;
            rd_data   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rd_reqcyc) begin
                        line_addr <= {rd_addr[63:6], 6'b0};
                        beat_cnt  <= '0;
                        state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus_reqack) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus_respcyc) begin
                        // Beat k occupies bits [511-64k -: 64], i.e. base 64*(7-k).
                        rd_data[{~beat_cnt, 6'b0} +: 64] <= beat_to_line_order(bus_resp);
                        beat_cnt <= beat_cnt + 3'd1;
                        if (beat_cnt == 3'(BEATS_PER_LINE - 1)) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus_reqcyc  = (state == ST_REQ);
    assign bus_req     = bus_reqcyc ? line_addr : '0;
    assign bus_reqtag  = bus_reqcyc ? TAG_MEM_READ : '0;
    assign bus_respack = (state == ST_RESP) && bus_respcyc;
    assign rd_respcyc  = (state == ST_DONE);

endmodule

// File: tb/tb_muskbus_reader.sv
// Scoreboard bench for muskbus_reader: the driver queues expected requests and
// lines, a negedge monitor pops and compares whenever the DUT presents them.
`timescale 1ns/1ps
module tb_muskbus_reader;

    logic         clk = 1'b0;
    logic         reset;
    logic         rd_reqcyc;
    logic [63:0]  rd_addr;
    logic         rd_respcyc;
    logic [511:0] rd_data;
    logic         bus_reqcyc;
    logic [63:0]  bus_req;
    logic [15:0]  bus_reqtag;
    logic         bus_reqack;
    logic         bus_respcyc;
    logic [63:0]  bus_resp;
    logic [15:0]  bus_resptag;
    logic         bus_respack;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [63:0]  addr_q[$];
    int           reqlen_q[$];
    logic [511:0] line_q[$];
    int           due_q[$];
    logic [511:0] last_line = '0;

    muskbus_reader dut (
        .clk         (clk),
        .reset       (reset),
        .rd_reqcyc   (rd_reqcyc),
        .rd_addr     (rd_addr),
        .rd_respcyc  (rd_respcyc),
        .rd_data     (rd_data),
        .bus_reqcyc  (bus_reqcyc),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_reqack  (bus_reqack),
        .bus_respcyc (bus_respcyc),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag),
        .bus_respack (bus_respack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got event with nothing expected", name);
    endtask

    // Monitor: bus request address/tag/length and completed lines with their cycle.
    initial begin
        int rc;
        rc = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (bus_reqcyc) begin
                    if (rc == 0) begin
                        if (addr_q.size() == 0) fail("unexpected_bus_req");
                        else check("bus_req", bus_req, addr_q.pop_front());
                        check("bus_reqtag", bus_reqtag, 16'h1800);
                    end
                    rc++;
                end else if (rc > 0) begin
                    if (reqlen_q.size() == 0) fail("unexpected_req_len");
                    else check("bus_reqcyc_cycles", rc, reqlen_q.pop_front());
                    rc = 0;
                end
                if (rd_respcyc) begin
                    if (line_q.size() == 0) fail("spurious_rd_respcyc");
                    else begin
                        check("rd_data", rd_data, line_q.pop_front());
                        check("rd_respcyc_cycle", cyc, due_q.pop_front());
                    end
                end
            end else begin
                rc = 0;
            end
        end
    end

    // One line fetch. gap_beat: beat index followed by one idle gap (-1 none).
    // abort_after: beat index after which reset is pulsed (-1 none).
    task automatic fetch(input logic [63:0] addr, input int ack_delay, input int gap_beat,
                         input bit hold, input bit seq, input int abort_after);
        logic [63:0]  beats[8];
        logic [511:0] exp_line;
        int           gaps;
        for (int k = 0; k < 8; k++) begin
            beats[k] = seq ? (64'h0706050403020100 + 64'h0808080808080808 * k)
                           : {$urandom, $urandom};
        end
        exp_line = '0;
        for (int i = 0; i < 64; i++) begin
            exp_line[511-8*i -: 8] = beats[i/8][8*(i%8) +: 8];
        end
        gaps = (gap_beat >= 0) ? 1 : 0;

        rd_reqcyc = 1'b1;
        rd_addr   = addr;
        addr_q.push_back({addr[63:6], 6'b0});
        reqlen_q.push_back(ack_delay + 1);
        if (abort_after < 0) begin
            line_q.push_back(exp_line);
            due_q.push_back(cyc + 10 + ack_delay + gaps);
        end
        @(posedge clk); #1;
        if (!hold) rd_reqcyc = 1'b0;
        rd_addr = {$urandom, $urandom};
        @(negedge clk);
        check("rd_data_hold", rd_data, last_line);
        for (int d = 0; d <= ack_delay; d++) begin
            bus_reqack = (d == ack_delay);
            @(posedge clk); #1;
        end
        bus_reqack = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus_respcyc = 1'b1;
            bus_resp    = beats[k];
            bus_resptag = 16'($urandom);
            @(negedge clk);
            check("respack_beat", bus_respack, 1'b1);
            @(posedge clk); #1;
            if (k == abort_after) begin
                rd_reqcyc = 1'b0;
                reset     = 1'b0;
                #1;
                check("abort_rd_respcyc", rd_respcyc, 1'b0);
                check("abort_bus_reqcyc", bus_reqcyc, 1'b0);
                check("abort_bus_req", bus_req, 64'h0);
                check("abort_bus_reqtag", bus_reqtag, 16'h0);
                check("abort_bus_respack", bus_respack, 1'b0);
                check("abort_rd_data", rd_data, 512'h0);
                @(posedge clk); #1;
                bus_respcyc = 1'b0;
                reset       = 1'b1;
                last_line   = '0;
                return;
            end
            if (k == gap_beat) begin
                bus_respcyc = 1'b0;
                bus_resp    = {$urandom, $urandom};
                @(negedge clk);
                check("respack_gap", bus_respack, 1'b0);
                @(posedge clk); #1;
            end
        end
        bus_respcyc = 1'b0;
        last_line   = exp_line;
        @(posedge clk); #1;
    endtask

    task automatic stray();
        rd_reqcyc   = 1'b0;
        bus_respcyc = 1'b1;
        bus_resp    = {$urandom, $urandom};
        @(negedge clk);
        check("stray_respack", bus_respack, 1'b0);
        @(posedge clk); #1;
        bus_respcyc = 1'b0;
        @(negedge clk);
        check("stray_rd_data", rd_data, last_line);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        rd_reqcyc   = 1'b0;
        rd_addr     = '0;
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b0;
        bus_resp    = '0;
        bus_resptag = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_rd_respcyc", rd_respcyc, 1'b0);
        check("reset_bus_reqcyc", bus_reqcyc, 1'b0);
        check("reset_bus_req", bus_req, 64'h0);
        check("reset_bus_reqtag", bus_reqtag, 16'h0);
        check("reset_bus_respack", bus_respack, 1'b0);
        check("reset_rd_data", rd_data, 512'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        fetch(64'h1000, 0, -1, 1'b0, 1'b1, -1);
        @(posedge clk); #1;
        fetch(64'h1027, 0, -1, 1'b0, 1'b1, -1);
        fetch(64'h4000_0000_0000_1240, 3, 3, 1'b0, 1'b0, -1);
        fetch(64'h3000, 0, -1, 1'b1, 1'b0, -1);
        fetch(64'h3047, 1, -1, 1'b0, 1'b0, -1);
        stray();
        fetch(64'h5000, 0, -1, 1'b0, 1'b0, 4);
        fetch(64'h2000, 0, -1, 1'b0, 1'b0, -1);

        for (int i = 0; i < 20; i++) begin
            fetch({$urandom, $urandom}, int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 7)) - 1,
                  (i < 19) ? 1'($urandom % 2) : 1'b0, 1'b0, -1);
            if ($urandom % 3 == 0) stray();
        end

        rd_reqcyc = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("pending_lines", line_q.size(), 0);
        check("pending_reqs", addr_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
